// File: rtl/display_scheduler.sv
// Frame scheduler for an 8x8 matrix display driver: scan/blank pacing, double-buffered
// frame store with tear-free commits applied during blanking, and frame-done checking.
module display_scheduler #(
  parameter int unsigned GS        = 8,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      en_i,
  input  logic                      wr_en_i,
  input  logic [$clog2(GS)-1:0]     wr_row_i,
  input  logic [GS-1:0]             wr_data_i,
  input  logic                      commit_i,
  output logic                      busy_o,
  output logic                      commit_ack_o,
  output logic [GS*GS-1:0]          matrix_o,
  output logic                      e_disp_o,
  input  logic                      d_disp_i,
  output logic                      frame_o,
  output logic                      err_o
);

  localparam int unsigned RW = (GS > 1) ? $clog2(GS) : 1;
  localparam int unsigned BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam int unsigned MW = GS * GS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    BLANK = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [BW-1:0]   blank_q, blank_d;
  logic            scan_done_c;
  logic [MW-1:0]   back_q;
  logic            wr_ok_c;

  assign wr_ok_c = wr_en_i && !busy_o;

  // Next-state logic; scan_done_c marks the edge that ends a scan and enters BLANK.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    blank_d     = blank_q;
    scan_done_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_i) begin
          state_d = SCAN;
          row_d   = '0;
        end
      end
      SCAN: begin
        if (row_q == RW'(GS - 1)) begin
          state_d     = BLANK;
          blank_d     = '0;
          scan_done_c = 1'b1;
        end else begin
          row_d = row_q + RW'(1);
        end
      end
      BLANK: begin
        if (blank_q == BW'(BLANK_CYC - 1)) begin
          state_d = en_i ? SCAN : IDLE;
          row_d   = '0;
        end else begin
          blank_d = blank_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters, frame buffers and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      row_q        <= '0;
      blank_q      <= '0;
      back_q       <= '0;
      matrix_o     <= '0;
      busy_o       <= 1'b0;
      commit_ack_o <= 1'b0;
      e_disp_o     <= 1'b0;
      frame_o      <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      blank_q      <= blank_d;
      e_disp_o     <= (state_d == SCAN);
      frame_o      <= scan_done_c;
      commit_ack_o <= scan_done_c && busy_o;
      if (scan_done_c && !d_disp_i) begin
        err_o <= 1'b1;
      end
      // Rows outside 0..GS-1 match no slice and are dropped.
      for (int unsigned r = 0; r < GS; r++) begin
        if (wr_ok_c && wr_row_i == RW'(r)) begin
          back_q[r*GS +: GS] <= wr_data_i;
        end
      end
      if (scan_done_c && busy_o) begin
        matrix_o <= back_q;
        busy_o   <= 1'b0;
      end else if (commit_i && !busy_o) begin
        busy_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler: cadence, commit/ack scoreboard, dropped writes,
// en_i drop, frame-done error, and mid-scan reset.
module tb_display_scheduler;

  localparam int unsigned GS = 8;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          en_i;
  logic          wr_en_i;
  logic [2:0]    wr_row_i;
  logic [GS-1:0] wr_data_i;
  logic          commit_i;
  logic          busy_o;
  logic          commit_ack_o;
  logic [63:0]   matrix_o;
  logic          e_disp_o;
  logic          d_disp_i;
  logic          frame_o;
  logic          err_o;

  logic          use_real;
  logic          d_tie;
  logic [2:0]    drv_cnt;

  int            checks = 0;
  int            errors = 0;
  logic [63:0]   exp_q[$];

  display_scheduler #(.GS(GS), .BLANK_CYC(16)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .en_i         (en_i),
    .wr_en_i      (wr_en_i),
    .wr_row_i     (wr_row_i),
    .wr_data_i    (wr_data_i),
    .commit_i     (commit_i),
    .busy_o       (busy_o),
    .commit_ack_o (commit_ack_o),
    .matrix_o     (matrix_o),
    .e_disp_o     (e_disp_o),
    .d_disp_i     (d_disp_i),
    .frame_o      (frame_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural driver: raises frame-done during the last enabled row of a scan.
  always @(posedge clk_i) begin
    if (rst_i) drv_cnt <= 3'd0;
    else if (e_disp_o) drv_cnt <= drv_cnt + 3'd1;
  end
  assign d_disp_i = use_real ? (e_disp_o && drv_cnt == 3'd7) : d_tie;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock; any ack is matched against the oldest expected front buffer.
  task automatic tick();
    logic [63:0] e;
    @(posedge clk_i);
    #1;
    if (commit_ack_o) begin
      if (exp_q.size() == 0) begin
        check("ack_unexpected", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        check("ack_matrix", matrix_o, e);
      end
    end
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      tick();
      n++;
    end while (!frame_o && n < 100);
    check("frame_seen", 64'(frame_o), 64'd1);
  endtask

  task automatic wait_scan();
    int n = 0;
    do begin
      tick();
      n++;
    end while (!e_disp_o && n < 100);
    check("scan_seen", 64'(e_disp_o), 64'd1);
  endtask

  task automatic wait_ack(input string tag, input int unsigned byte_lo);
    int n = 0;
    logic [63:0] m;
    do begin
      m = matrix_o;
      if (!commit_ack_o) check({tag, "_hold"}, 64'(m[byte_lo +: 8]), 64'(8'h00));
      tick();
      n++;
    end while (!commit_ack_o && n < 60);
    check({tag, "_ack"}, 64'(commit_ack_o), 64'd1);
    check({tag, "_busy_clr"}, 64'(busy_o), 64'd0);
    check({tag, "_ack_frame"}, 64'(frame_o), 64'd1);
  endtask

  initial begin
    rst_i = 1'b1; en_i = 1'b1; wr_en_i = 1'b0; wr_row_i = '0; wr_data_i = '0;
    commit_i = 1'b0; use_real = 1'b1; d_tie = 1'b0;

    // Reset with en_i held high
    tick(); tick();
    check("rst_e_disp", 64'(e_disp_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_matrix", matrix_o, 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_frame", 64'(frame_o), 64'd0);
    check("rst_ack", 64'(commit_ack_o), 64'd0);
    rst_i = 1'b0;

    // T1: 8 scan / 16 blank cadence, frame pulse on first blank cycle
    for (int k = 0; k < 48; k++) begin
      tick();
      check("t1_e_disp", 64'(e_disp_o), 64'((k % 24) < 8));
      check("t1_frame", 64'(frame_o), 64'((k % 24) == 8));
    end
    check("t1_err", 64'(err_o), 64'd0);

    // T2: write row3 then commit; front updates only at the next first-blank edge
    wait_frame();
    wr_en_i = 1'b1; wr_row_i = 3'd3; wr_data_i = 8'hA5;
    tick();
    wr_en_i = 1'b0; commit_i = 1'b1;
    exp_q.push_back(64'h0000_0000_A500_0000);
    tick();
    commit_i = 1'b0;
    check("t2_busy", 64'(busy_o), 64'd1);
    wait_ack("t2", 24);
    tick();
    check("t2_ack_pulse", 64'(commit_ack_o), 64'd0);
    check("t2_row3", 64'(matrix_o[31:24]), 64'(8'hA5));

    // Write and commit in the same cycle: commit captures the new row
    wr_en_i = 1'b1; wr_row_i = 3'd0; wr_data_i = 8'h3C; commit_i = 1'b1;
    exp_q.push_back(64'h0000_0000_A500_003C);
    tick();
    wr_en_i = 1'b0; commit_i = 1'b0;
    check("t2b_busy", 64'(busy_o), 64'd1);
    wait_ack("t2b", 0);

    // T3: write while busy is dropped
    commit_i = 1'b1;
    exp_q.push_back(64'h0000_0000_A500_003C);
    tick();
    commit_i = 1'b0;
    check("t3_busy", 64'(busy_o), 64'd1);
    wr_en_i = 1'b1; wr_row_i = 3'd5; wr_data_i = 8'hFF;
    tick();
    wr_en_i = 1'b0;
    wait_ack("t3", 40);
    check("t3_row5", 64'(matrix_o[47:40]), 64'(8'h00));

    // T5b: real driver attached, no error over 100 frames
    for (int f = 0; f < 100; f++) begin
      wait_frame();
      check("t5_real_err", 64'(err_o), 64'd0);
    end

    // T4: en_i dropped during the 3rd scan cycle
    wait_scan();
    tick(); tick();
    en_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_scan_tail", 64'(e_disp_o), 64'd1);
    end
    for (int i = 0; i < 46; i++) begin
      tick();
      check("t4_off", 64'(e_disp_o), 64'd0);
      check("t4_frame", 64'(frame_o), 64'(i == 0));
    end

    // T5: frame-done tied low sets sticky err_o
    use_real = 1'b0; d_tie = 1'b0; en_i = 1'b1;
    tick();
    check("t5_err_pre", 64'(err_o), 64'd0);
    wait_frame();
    check("t5_err_set", 64'(err_o), 64'd1);
    use_real = 1'b1;
    wait_frame();
    check("t5_err_sticky", 64'(err_o), 64'd1);

    // T6: reset mid-scan with a commit pending
    wr_en_i = 1'b1; wr_row_i = 3'd7; wr_data_i = 8'h81; commit_i = 1'b1;
    tick();
    wr_en_i = 1'b0; commit_i = 1'b0;
    check("t6_busy", 64'(busy_o), 64'd1);
    wait_scan();
    tick(); tick();
    rst_i = 1'b1;
    exp_q.delete();
    tick();
    check("t6_e_disp", 64'(e_disp_o), 64'd0);
    check("t6_busy_clr", 64'(busy_o), 64'd0);
    check("t6_matrix", matrix_o, 64'd0);
    check("t6_err", 64'(err_o), 64'd0);
    rst_i = 1'b0;

    // Back buffer was cleared by reset: an empty commit yields a zero front
    commit_i = 1'b1;
    exp_q.push_back(64'd0);
    tick();
    commit_i = 1'b0;
    wait_ack("t6_post", 56);
    check("t6_q_empty", 64'(exp_q.size()), 64'd0);
    check("t6_err_post", 64'(err_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
